// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares the single write port of a small byte FIFO between NREQ producers.
//   A round-robin arbiter grants one producer at a time for a burst of at most
//   MAX_BURST beats. Accepted bytes pass through a one-deep registered write
//   stage, so every accepted beat appears on the FIFO port exactly one cycle
//   later. Acceptance is throttled on FIFO occupancy, counting the write that
//   may already be sitting in the output register.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   req_valid     in   [NREQ]      per-requester data valid
//   req_data      in   [NREQ*DW]   packed data, requester i at [i*DW +: DW]
//   req_last      in   [NREQ]      final beat of requester i's burst
//   req_ready     out  [NREQ]      per-requester accept (one-hot or zero)
//   fifo_wr_en    out             registered FIFO write strobe
//   fifo_data_in  out  [DW]       registered FIFO write data
//   fifo_full     in              FIFO full flag
//   fifo_words    in   [4]        FIFO occupancy, 0..DEPTH
//   grant_id      out  [IW]       current or most recent owner
//   busy          out             high while a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4,
   localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    req_ready,
   output logic               fifo_wr_en,
   output logic [DW-1:0]      fifo_data_in,
   input  logic               fifo_full,
   input  logic [3:0]         fifo_words,
   output logic [IW-1:0]      grant_id,
   output logic               busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   state_t          state_q,      state_d;
   logic [IW-1:0]   owner_q,      owner_d;
   logic [IW-1:0]   last_owner_q, last_owner_d;
   logic [3:0]      beat_cnt_q,   beat_cnt_d;
   logic            wr_en_q,      wr_en_d;
   logic [DW-1:0]   data_q,       data_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [DW-1:0]   req_word [NREQ];
   logic [DW-1:0]   owner_data;
   logic [4:0]      occ_sum;
   logic            stall;
   logic            granted;
   logic            beat;
   logic            owner_valid;
   logic            owner_last;
   logic [3:0]      beat_cnt_inc;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;

   // Index of the k-th candidate after 'base' in round-robin order.
   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      int sum;
      sum = (int'(base) + k) % NREQ;
      return sum[IW-1:0];
   endfunction

   // Unpack the flat data bus so the owner's word can be selected by index.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign req_word[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   assign owner_data  = req_word[owner_q];
   assign owner_valid = req_valid[owner_q];
   assign owner_last  = req_last[owner_q];
   assign granted     = (state_q == GRANT);

   // A write held in the output register lands in the FIFO on the next edge,
   // so it must be counted against the free space before accepting again.
   assign occ_sum = {1'b0, fifo_words} + {4'b0000, wr_en_q};
   assign stall   = fifo_full | (occ_sum >= 5'(DEPTH));

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = granted && (owner_q == IW'(gi)) && !stall;
      end
   endgenerate

   assign beat         = granted && owner_valid && !stall;
   assign beat_cnt_inc = beat_cnt_q + 4'd1;

   // Round-robin pick: scan last_owner+1, +2, ... and keep the first hit.
   // Iterating from the farthest candidate down lets the nearest one win.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[rr_idx(last_owner_q, k)]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_idx(last_owner_q, k);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      // The write stage simply mirrors the accept of this cycle; data only
      // moves on an accepted beat, otherwise the register holds.
      wr_en_d      = beat;
      data_d       = beat ? owner_data : data_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d    = pick_idx;
               beat_cnt_d = 4'd0;
               state_d    = GRANT;
            end
         end

         GRANT: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_inc;
               // A last beat landing on the burst limit is a single exit.
               if (owner_last || (beat_cnt_inc == 4'(MAX_BURST))) begin
                  state_d      = IDLE;
                  last_owner_d = owner_q;
               end
            end else if (!owner_valid && !stall) begin
               // Voluntary release only counts when the FIFO is not
               // throttling; a drop during a stall keeps the grant.
               state_d      = IDLE;
               last_owner_d = owner_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         // Starting from the top index gives requester 0 first priority.
         last_owner_q <= IW'(NREQ - 1);
         beat_cnt_q   <= 4'd0;
         wr_en_q      <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
         wr_en_q      <= wr_en_d;
         data_q       <= data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign fifo_wr_en   = wr_en_q;
   assign fifo_data_in = data_q;
   assign grant_id     = owner_q;
   assign busy         = granted;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Drives fifo_wr_arbiter with per-requester producer queues and a simple FIFO
// occupancy model. A behavioural reference model predicts grants, req_ready and
// the bytes that must reach the FIFO; predicted writes go into a scoreboard
// queue that an independent monitor drains whenever fifo_wr_en is seen.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int DEPTH     = 8;
   localparam int MAX_BURST = 4;
   localparam int IW        = 2;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_data_in;
   logic               fifo_full;
   logic [3:0]         fifo_words;
   logic [IW-1:0]      grant_id;
   logic               busy;

   fifo_wr_arbiter #(
      .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
      .fifo_full(fifo_full), .fifo_words(fifo_words),
      .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO occupancy seen by the DUT
   logic [3:0] words;
   int         words_next;
   bit         rd;
   assign fifo_words = words;
   assign fifo_full  = (words == 4'(DEPTH));

   // Producers: each holds a queue of {last, data} items
   logic [8:0] pq [NREQ][$];
   int pv, pr, pl;          // valid %, read %, last %
   bit refill;

   // Scoreboard
   typedef struct packed { logic [7:0] d; int due; } exp_t;
   exp_t sb [$];
   logic [7:0] hold_data;

   // Reference model state
   bit m_grant;
   int m_owner, m_last, m_cnt;
   bit m_wr;

   int checks = 0;
   int errors = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_grant   = 0;
      m_owner   = 0;
      m_last    = NREQ - 1;
      m_cnt     = 0;
      m_wr      = 0;
      hold_data = '0;
      sb.delete();
   endtask

   task automatic refill_queues();
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() == 0) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
               logic [8:0] it;
               it[7:0] = 8'($urandom);
               it[8]   = ($urandom_range(99) < pl);
               pq[i].push_back(it);
            end
         end
      end
   endtask

   // Called just after a rising edge: apply FIFO update and new inputs.
   task automatic drive();
      words = 4'(words_next);
      if (refill) refill_queues();
      for (int i = 0; i < NREQ; i++) begin
         if (pq[i].size() > 0 && $urandom_range(99) < pv) begin
            req_valid[i]          = 1'b1;
            req_data[i*DW +: DW]  = pq[i][0][7:0];
            req_last[i]           = pq[i][0][8];
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*DW +: DW]  = 8'($urandom);   // must be ignored
            req_last[i]           = 1'($urandom);
         end
      end
      rd = ($urandom_range(99) < pr);
   endtask

   // Called on a falling edge: check this cycle, then advance the model.
   task automatic eval();
      bit stall, beat, found;
      int exp_ready, wn, pick;
      stall     = (int'(words) == DEPTH) || (int'(words) + int'(m_wr) >= DEPTH);
      exp_ready = (m_grant && !stall) ? (1 << m_owner) : 0;
      check(int'(req_ready) == exp_ready, "req_ready", int'(req_ready), exp_ready);
      check(busy == m_grant, "busy", int'(busy), int'(m_grant));
      check(int'(grant_id) == m_owner, "grant_id", int'(grant_id), m_owner);

      // FIFO side: the write visible now lands on the coming edge.
      wn = int'(words);
      if (fifo_wr_en) begin
         check(int'(words) < DEPTH, "no_write_when_full", int'(words), DEPTH - 1);
         wn++;
      end
      if (rd && words > 0) wn--;
      words_next = wn;

      beat = m_grant && req_valid[m_owner] && !stall;
      m_wr = beat;
      if (beat) begin
         exp_t e;
         e.d   = req_data[m_owner*DW +: DW];
         e.due = cyc + 1;
         sb.push_back(e);
         void'(pq[m_owner].pop_front());
      end

      if (!m_grant) begin
         found = 0;
         pick  = 0;
         for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(m_last + k) % NREQ]) begin
               found = 1;
               pick  = (m_last + k) % NREQ;
            end
         end
         if (found) begin
            m_grant = 1;
            m_owner = pick;
            m_cnt   = 0;
            $display("cycle %0d: grant -> requester %0d", cyc + 1, pick);
         end
      end else if (beat) begin
         m_cnt++;
         if (req_last[m_owner] || m_cnt == MAX_BURST) begin
            m_grant = 0;
            m_last  = m_owner;
         end
      end else if (!req_valid[m_owner] && !stall) begin
         m_grant = 0;
         m_last  = m_owner;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive();
         @(negedge clk);
         eval();
      end
   endtask

   // Release reset just after an edge and model the current cycle at once.
   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();
      @(negedge clk);
      eval();
   endtask

   // Monitor: consumes scoreboard entries on every observed FIFO write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (fifo_wr_en) begin
               check(sb.size() > 0, "unexpected_write", int'(fifo_data_in), -1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check(e.due == cyc, "write_latency", cyc, e.due);
                  check(fifo_data_in == e.d, "write_data", int'(fifo_data_in), int'(e.d));
                  hold_data = e.d;
                  $display("cycle %0d: fifo write 0x%02h (owner %0d)", cyc, fifo_data_in, grant_id);
               end
            end else begin
               if (sb.size() > 0 && sb[0].due <= cyc) begin
                  e = sb.pop_front();
                  check(1'b0 == fifo_wr_en && 1'b0, "missing_write", 0, int'(e.d));
               end
               check(fifo_data_in == hold_data, "data_hold", int'(fifo_data_in), int'(hold_data));
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      req_last   = '0;
      words      = '0;
      words_next = 0;
      rd         = 0;
      pv = 100; pr = 100; pl = 30; refill = 0;
      model_reset();

      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check(fifo_wr_en == 1'b0,   "rst_wr_en",   int'(fifo_wr_en),   0);
      check(fifo_data_in == 8'h0, "rst_data",    int'(fifo_data_in), 0);
      check(busy == 1'b0,         "rst_busy",    int'(busy),         0);
      check(req_ready == '0,      "rst_ready",   int'(req_ready),    0);
      check(grant_id == '0,       "rst_grant",   int'(grant_id),     0);
      repeat (2) @(posedge clk);
      release_reset();

      // Single producer: requester 2 sends 11, 22, 33(last)
      pq[2].push_back(9'h011);
      pq[2].push_back(9'h022);
      pq[2].push_back(9'h133);
      run(10);

      // All requesters valid with 1-beat bursts
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < 4; j++) pq[i].push_back({1'b1, 8'($urandom)});
      run(40);

      // Burst limit: req 1 streams 10 beats with no last, req 3 also valid
      for (int j = 0; j < 10; j++) pq[1].push_back({1'b0, 8'(8'h40 + j)});
      for (int j = 0; j < 3; j++)  pq[3].push_back({(j == 2), 8'(8'hC0 + j)});
      run(40);

      // Occupancy throttling: no reads until full, then drain
      pr = 0;
      for (int j = 0; j < 12; j++) pq[0].push_back({1'b0, 8'($urandom)});
      run(20);
      pr = 100;
      run(30);

      // Random traffic with voluntary drops, stalls and data churn
      refill = 1;
      pv = 70; pr = 50; pl = 30;
      run(400);
      pv = 95; pr = 25; pl = 10;
      run(400);
      refill = 0;

      // Asynchronous reset mid-burst
      pv = 100; pr = 100;
      for (int i = 0; i < NREQ; i++) begin
         pq[i].delete();
         for (int j = 0; j < 6; j++) pq[i].push_back({1'b0, 8'($urandom)});
      end
      run(3);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check(fifo_wr_en == 1'b0, "midrst_wr_en", int'(fifo_wr_en), 0);
      check(busy == 1'b0,       "midrst_busy",  int'(busy),       0);
      check(req_ready == '0,    "midrst_ready", int'(req_ready),  0);
      model_reset();
      words = 4'(words_next);
      words_next = int'(words);
      @(posedge clk);
      #1;
      check(fifo_wr_en == 1'b0, "rst_hold_wr_en", int'(fifo_wr_en), 0);
      release_reset();
      run(20);

      // Drain: no more requests, every predicted write must have appeared
      for (int i = 0; i < NREQ; i++) pq[i].delete();
      run(10);
      check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
